// File: rtl/activation_to_video_sink.sv
// Converts the signed 3-channel activation stream to 8-bit RGB AXI4-Stream video beats
// with start-of-frame/end-of-line tags, and counts pixels that needed clamping.
module activation_to_video_sink #(
    parameter int Height          = 600,
    parameter int Width           = 800,
    parameter int ActivationWidth = 10,
    parameter int Shift           = 1,
    parameter int StatWidth       = 32
) (
    input  logic                         clock_i,
    input  logic                         reset_ni,
    input  logic                         slave_valid_i,
    output logic                         slave_ready_o,
    input  logic [3*ActivationWidth-1:0] slave_data_i,
    output logic                         master_valid_o,
    input  logic                         master_ready_i,
    output logic [23:0]                  master_data_o,
    output logic                         master_user_o,
    output logic                         master_last_o,
    input  logic                         clear_stats_i,
    output logic [StatWidth-1:0]         clamp_count_o
);

    localparam int AW       = ActivationWidth;
    localparam int RowW     = (Height > 1) ? $clog2(Height) : 1;
    localparam int ColW     = (Width > 1) ? $clog2(Width) : 1;
    localparam int RoundInt = (Shift > 0) ? (1 << (Shift - 1)) : 0;

    localparam logic signed [AW:0]     RoundVal = RoundInt[AW:0];
    localparam logic signed [AW:0]     MaxPix   = (AW + 1)'(255);
    localparam logic [ColW-1:0]        ColLast  = ColW'(Width - 1);
    localparam logic [RowW-1:0]        RowLast  = RowW'(Height - 1);
    localparam logic [StatWidth-1:0]   StatMax  = '1;

    // Stage valid flags are the only control state; both stages are simple registers.
    logic                 s1_valid_q, s2_valid_q;
    logic [23:0]          s1_data_q, s2_data_q;
    logic                 s1_user_q, s2_user_q;
    logic                 s1_last_q, s2_last_q;
    logic [ColW-1:0]      col_q, col_d;
    logic [RowW-1:0]      row_q, row_d;
    logic [StatWidth-1:0] count_q, count_d;

    logic                 s2_adv;
    logic                 accept;
    logic [23:0]          pix_d;
    logic                 clamped_d;
    logic                 user_d;
    logic                 last_d;
    logic signed [AW:0]   sum_c [3];
    logic signed [AW:0]   res_c [3];

    // Valid/ready: a beat transfers on a cycle where valid and ready are both high;
    // the output beat is held unchanged while valid is high and ready is low.
    assign s2_adv        = !s2_valid_q || master_ready_i;
    assign slave_ready_o = !s1_valid_q || s2_adv;
    assign accept        = slave_valid_i && slave_ready_o;

    always_comb begin
        pix_d     = '0;
        clamped_d = 1'b0;
        sum_c     = '{default: '0};
        res_c     = '{default: '0};
        for (int c = 0; c < 3; c++) begin
            sum_c[c] = $signed({slave_data_i[c*AW+AW-1], slave_data_i[c*AW +: AW]}) + RoundVal;
            res_c[c] = sum_c[c] >>> Shift;
            if (res_c[c] < 0) begin
                pix_d[c*8 +: 8] = 8'd0;
                clamped_d       = 1'b1;
            end else if (res_c[c] > MaxPix) begin
                pix_d[c*8 +: 8] = 8'd255;
                clamped_d       = 1'b1;
            end else begin
                pix_d[c*8 +: 8] = res_c[c][7:0];
            end
        end
    end

    always_comb begin
        user_d  = (row_q == '0) && (col_q == '0);
        last_d  = (col_q == ColLast);
        col_d   = col_q;
        row_d   = row_q;
        count_d = count_q;
        if (accept) begin
            if (col_q == ColLast) begin
                col_d = '0;
                row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        // Clear wins over a same-cycle increment.
        if (clear_stats_i) begin
            count_d = '0;
        end else if (accept && clamped_d && (count_q != StatMax)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_user_q  <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_user_q  <= 1'b0;
            s2_last_q  <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            count_q    <= '0;
        end else begin
            if (slave_ready_o) begin
                s1_valid_q <= slave_valid_i;
                if (accept) begin
                    s1_data_q <= pix_d;
                    s1_user_q <= user_d;
                    s1_last_q <= last_d;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= s1_data_q;
                    s2_user_q <= s1_user_q;
                    s2_last_q <= s1_last_q;
                end
            end
            col_q   <= col_d;
            row_q   <= row_d;
            count_q <= count_d;
        end
    end

    assign master_valid_o = s2_valid_q;
    assign master_data_o  = s2_data_q;
    assign master_user_o  = s2_user_q;
    assign master_last_o  = s2_last_q;
    assign clamp_count_o  = count_q;

endmodule
